stepper_profile: RTL and testbench

STEPPER_PROFILE -- requirements
Module: stepper_profile

---
 rtl/motor_pkg.sv | 18 +
 rtl/sync2.sv | 25 ++
 rtl/stepper_profile.sv | 182 ++++++++++++++++++
 tb/tb_stepper_profile.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/motor_pkg.sv
// Shared definitions for the stepper motion profile: controller states and
// default speed-code settings.
package motor_pkg;

  localparam logic [15:0] SPEED_SLOW_DEF = 16'd60000;
  localparam logic [15:0] SPEED_FAST_DEF = 16'd0;
  localparam logic [15:0] ACCEL_STEP_DEF = 16'd500;

  typedef enum logic [2:0] {
    IDLE,
    ACCEL,
    CRUISE,
    DECEL,
    HOMING,
    FAULT
  } state_t;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for asynchronous motor-driver pins. Flops reset to 1
// so the active-low pins read inactive while in reset.
module sync2 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  // Double-register the pins into the clk domain.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/stepper_profile.sv
// Trapezoidal stepper motion profile controller. Accepts relative moves and
// homing commands, ramps the speed code per counted step, tracks absolute
// position and reacts to abort, driver fault and home switch.
module stepper_profile
  import motor_pkg::*;
#(
  parameter logic [15:0] SPEED_SLOW = SPEED_SLOW_DEF,
  parameter logic [15:0] SPEED_FAST = SPEED_FAST_DEF,
  parameter logic [15:0] ACCEL_STEP = ACCEL_STEP_DEF,
  parameter logic        HOME_DIR   = 1'b0
) (
  input  logic               clk_100M,
  input  logic               nrst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_home,
  input  logic               cmd_dir,
  input  logic [23:0]        cmd_steps,
  input  logic               abort,
  input  logic               clr_fault,
  input  logic               mtr_step,
  input  logic               mtr_nhome,
  input  logic               mtr_nflt,
  output logic               en,
  output logic               dir,
  output logic [15:0]        speed,
  output logic               busy,
  output logic               done,
  output logic               fault,
  output logic signed [31:0] position
);

  state_t      state;
  logic [1:0]  pins_s;
  logic        nhome_s;
  logic        nflt_s;
  logic        step_q;
  logic        step_cnt;
  logic [23:0] remaining;
  logic [23:0] ramp_cnt;
  logic [23:0] rem_n;
  logic        ramp_down;
  logic [15:0] spd_dn;
  logic [15:0] spd_up;

  // Faster step: subtract ACCEL_STEP but never go below SPEED_FAST (no wrap).
  function automatic logic [15:0] speed_down(input logic [15:0] s);
    logic [16:0] floor_v;
    floor_v = {1'b0, SPEED_FAST} + {1'b0, ACCEL_STEP};
    if ({1'b0, s} > floor_v) return s - ACCEL_STEP;
    else                     return SPEED_FAST;
  endfunction

  // Slower step: add ACCEL_STEP but never exceed SPEED_SLOW (no wrap).
  function automatic logic [15:0] speed_up(input logic [15:0] s);
    logic [16:0] sum;
    sum = {1'b0, s} + {1'b0, ACCEL_STEP};
    if (sum > {1'b0, SPEED_SLOW}) return SPEED_SLOW;
    else                          return sum[15:0];
  endfunction

  sync2 #(.W(2)) u_sync (
    .clk  (clk_100M),
    .nrst (nrst),
    .d    ({mtr_nflt, mtr_nhome}),
    .q    (pins_s)
  );

  assign nhome_s  = pins_s[0];
  assign nflt_s   = pins_s[1];
  assign step_cnt = mtr_step & ~step_q & en;
  assign rem_n    = remaining - 24'd1;
  // A step becomes a decel step once the steps left after it no longer exceed
  // the steps spent accelerating, so the ramp down mirrors the ramp up.
  assign ramp_down = (state == DECEL) || (rem_n <= ramp_cnt);
  assign spd_dn    = speed_down(speed);
  assign spd_up    = speed_up(speed);

  // Controller FSM with registered outputs, position counter and step edge detect.
  always_ff @(posedge clk_100M or negedge nrst) begin
    if (!nrst) begin
      state     <= IDLE;
      cmd_ready <= 1'b1;
      en        <= 1'b0;
      dir       <= 1'b0;
      speed     <= SPEED_SLOW;
      busy      <= 1'b0;
      done      <= 1'b0;
      fault     <= 1'b0;
      position  <= '0;
      remaining <= '0;
      ramp_cnt  <= '0;
      step_q    <= 1'b0;
    end else begin
      step_q <= mtr_step;
      done   <= 1'b0;
      if (!nflt_s) begin
        // Driver fault overrides stepping, abort and completion.
        state     <= FAULT;
        en        <= 1'b0;
        busy      <= 1'b0;
        fault     <= 1'b1;
        cmd_ready <= 1'b0;
      end else begin
        if (step_cnt) position <= dir ? position + 32'sd1 : position - 32'sd1;
        case (state)
          IDLE: begin
            if (cmd_valid && cmd_ready) begin
              if (cmd_home) begin
                dir       <= HOME_DIR;
                speed     <= SPEED_SLOW;
                en        <= 1'b1;
                busy      <= 1'b1;
                cmd_ready <= 1'b0;
                state     <= HOMING;
              end else if (cmd_steps == 24'd0) begin
                done <= 1'b1;
              end else begin
                dir       <= cmd_dir;
                remaining <= cmd_steps;
                ramp_cnt  <= '0;
                speed     <= SPEED_SLOW;
                en        <= 1'b1;
                busy      <= 1'b1;
                cmd_ready <= 1'b0;
                state     <= ACCEL;
              end
            end
          end
          ACCEL, CRUISE, DECEL: begin
            if (abort) begin
              en        <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
              cmd_ready <= 1'b1;
              remaining <= '0;
              ramp_cnt  <= '0;
              state     <= IDLE;
            end else if (step_cnt) begin
              remaining <= rem_n;
              if (ramp_down) begin
                speed    <= spd_up;
                ramp_cnt <= (ramp_cnt == 24'd0) ? 24'd0 : ramp_cnt - 24'd1;
                state    <= DECEL;
              end else if (state == ACCEL) begin
                speed    <= spd_dn;
                ramp_cnt <= ramp_cnt + 24'd1;
                state    <= (spd_dn == SPEED_FAST) ? CRUISE : ACCEL;
              end
              if (rem_n == 24'd0) begin
                en        <= 1'b0;
                busy      <= 1'b0;
                done      <= 1'b1;
                cmd_ready <= 1'b1;
                state     <= IDLE;
              end
            end
          end
          HOMING: begin
            if (abort || !nhome_s) begin
              en        <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
              cmd_ready <= 1'b1;
              state     <= IDLE;
              if (!abort) position <= '0;
            end
          end
          FAULT: begin
            if (clr_fault) begin
              fault     <= 1'b0;
              cmd_ready <= 1'b1;
              state     <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_stepper_profile.sv
// Directed bench for stepper_profile: moves, zero move, homing, fault,
// abort and mid-move reset, with hand-computed expectations.
module tb_stepper_profile;

  logic               clk = 1'b0;
  logic               nrst;
  logic               cmd_valid, cmd_ready, cmd_home, cmd_dir;
  logic [23:0]        cmd_steps;
  logic               abort, clr_fault;
  logic               mtr_step, mtr_nhome, mtr_nflt;
  logic               en, dir, busy, done, fault;
  logic [15:0]        speed;
  logic signed [31:0] position;

  int errors = 0;
  int checks = 0;
  int done_seen = 0;

  stepper_profile dut (
    .clk_100M  (clk),
    .nrst      (nrst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_home  (cmd_home),
    .cmd_dir   (cmd_dir),
    .cmd_steps (cmd_steps),
    .abort     (abort),
    .clr_fault (clr_fault),
    .mtr_step  (mtr_step),
    .mtr_nhome (mtr_nhome),
    .mtr_nflt  (mtr_nflt),
    .en        (en),
    .dir       (dir),
    .speed     (speed),
    .busy      (busy),
    .done      (done),
    .fault     (fault),
    .position  (position)
  );

  always #5 clk = ~clk;

  task automatic step_pulse();
    mtr_step = 1'b1;
    @(negedge clk); if (done) done_seen++;
    @(negedge clk); if (done) done_seen++;
    mtr_step = 1'b0;
    @(negedge clk); if (done) done_seen++;
    @(negedge clk); if (done) done_seen++;
  endtask

  task automatic issue(input logic home, input logic d, input logic [23:0] n);
    cmd_valid = 1'b1; cmd_home = home; cmd_dir = d; cmd_steps = n;
    @(negedge clk);
    cmd_valid = 1'b0;
    if (done) done_seen++;
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (en !== 1'b0) begin errors++; $display("FAIL reset_en: got %0d want 0", en); end
    checks++; if (dir !== 1'b0) begin errors++; $display("FAIL reset_dir: got %0d want 0", dir); end
    checks++; if (speed !== 16'd60000) begin errors++; $display("FAIL reset_speed: got %0d want 60000", speed); end
    checks++; if (busy !== 1'b0 || done !== 1'b0 || fault !== 1'b0) begin errors++; $display("FAIL reset_flags: got busy=%0d done=%0d fault=%0d want 0 0 0", busy, done, fault); end
    checks++; if (position !== 32'sd0) begin errors++; $display("FAIL reset_position: got %0d want 0", position); end
    nrst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %0d want 1", cmd_ready); end
  endtask

  task automatic test_zero_steps();
    issue(1'b0, 1'b1, 24'd0);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL zero_done: got %0d want 1", done); end
    checks++; if (en !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL zero_en_ready: got en=%0d ready=%0d want 0 1", en, cmd_ready); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL zero_done_width: got %0d want 0", done); end
  endtask

  task automatic test_move_200();
    done_seen = 0;
    issue(1'b0, 1'b1, 24'd200);
    checks++; if (en !== 1'b1 || busy !== 1'b1 || cmd_ready !== 1'b0) begin errors++; $display("FAIL m200_start: got en=%0d busy=%0d ready=%0d want 1 1 0", en, busy, cmd_ready); end
    checks++; if (speed !== 16'd60000) begin errors++; $display("FAIL m200_speed0: got %0d want 60000", speed); end
    for (int i = 1; i <= 200; i++) begin
      step_pulse();
      if (i == 100) begin
        checks++; if (speed !== 16'd10000) begin errors++; $display("FAIL m200_speed100: got %0d want 10000", speed); end
      end
      if (i == 101) begin
        checks++; if (speed !== 16'd10500) begin errors++; $display("FAIL m200_speed101: got %0d want 10500", speed); end
      end
    end
    checks++; if (speed !== 16'd60000) begin errors++; $display("FAIL m200_speed_end: got %0d want 60000", speed); end
    checks++; if (en !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL m200_end: got en=%0d busy=%0d ready=%0d want 0 0 1", en, busy, cmd_ready); end
    checks++; if (done_seen != 1) begin errors++; $display("FAIL m200_done_count: got %0d want 1", done_seen); end
    checks++; if (position !== 32'sd200) begin errors++; $display("FAIL m200_position: got %0d want 200", position); end
  endtask

  task automatic test_move_3();
    done_seen = 0;
    issue(1'b0, 1'b0, 24'd3);
    checks++; if (speed !== 16'd60000 || dir !== 1'b0) begin errors++; $display("FAIL m3_start: got speed=%0d dir=%0d want 60000 0", speed, dir); end
    step_pulse();
    checks++; if (speed !== 16'd59500) begin errors++; $display("FAIL m3_speed1: got %0d want 59500", speed); end
    step_pulse();
    checks++; if (speed !== 16'd60000) begin errors++; $display("FAIL m3_speed2: got %0d want 60000", speed); end
    step_pulse();
    checks++; if (en !== 1'b0 || speed !== 16'd60000) begin errors++; $display("FAIL m3_end: got en=%0d speed=%0d want 0 60000", en, speed); end
    checks++; if (done_seen != 1) begin errors++; $display("FAIL m3_done_count: got %0d want 1", done_seen); end
    checks++; if (position !== 32'sd197) begin errors++; $display("FAIL m3_position: got %0d want 197", position); end
  endtask

  task automatic test_homing();
    done_seen = 0;
    issue(1'b1, 1'b1, 24'd77);
    checks++; if (dir !== 1'b0 || en !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL home_start: got dir=%0d en=%0d busy=%0d want 0 1 1", dir, en, busy); end
    for (int i = 0; i < 50; i++) step_pulse();
    checks++; if (position !== 32'sd147) begin errors++; $display("FAIL home_position50: got %0d want 147", position); end
    mtr_nhome = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (done) done_seen++;
      if (!en) break;
    end
    checks++; if (en !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL home_stop: got en=%0d busy=%0d want 0 0 within 3 cycles", en, busy); end
    checks++; if (position !== 32'sd0) begin errors++; $display("FAIL home_position: got %0d want 0", position); end
    checks++; if (done_seen != 1) begin errors++; $display("FAIL home_done_count: got %0d want 1", done_seen); end
    // Home switch already active at acceptance: finishes in two cycles.
    issue(1'b1, 1'b1, 24'd5);
    @(negedge clk);
    checks++; if (done !== 1'b1 || en !== 1'b0) begin errors++; $display("FAIL home_already: got done=%0d en=%0d want 1 0", done, en); end
    mtr_nhome = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_fault();
    done_seen = 0;
    issue(1'b0, 1'b1, 24'd1000);
    for (int i = 0; i < 40; i++) step_pulse();
    checks++; if (position !== 32'sd40) begin errors++; $display("FAIL fault_position40: got %0d want 40", position); end
    mtr_nflt = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (done) done_seen++;
      if (fault && !en) break;
    end
    checks++; if (en !== 1'b0 || fault !== 1'b1) begin errors++; $display("FAIL fault_entry: got en=%0d fault=%0d want 0 1 within 3 cycles", en, fault); end
    repeat (3) begin @(negedge clk); if (done) done_seen++; end
    checks++; if (done_seen != 0) begin errors++; $display("FAIL fault_no_done: got %0d want 0", done_seen); end
    clr_fault = 1'b1;
    @(negedge clk);
    clr_fault = 1'b0;
    @(negedge clk);
    checks++; if (fault !== 1'b1 || cmd_ready !== 1'b0) begin errors++; $display("FAIL fault_clr_ignored: got fault=%0d ready=%0d want 1 0", fault, cmd_ready); end
    mtr_nflt = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (fault !== 1'b1) begin errors++; $display("FAIL fault_sticky: got %0d want 1", fault); end
    clr_fault = 1'b1;
    @(negedge clk);
    clr_fault = 1'b0;
    checks++; if (fault !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL fault_clear: got fault=%0d ready=%0d busy=%0d want 0 1 0", fault, cmd_ready, busy); end
    checks++; if (position !== 32'sd40) begin errors++; $display("FAIL fault_position: got %0d want 40", position); end
  endtask

  task automatic test_abort();
    issue(1'b0, 1'b1, 24'd500);
    for (int i = 0; i < 10; i++) step_pulse();
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++; if (en !== 1'b0 || done !== 1'b1) begin errors++; $display("FAIL abort_stop: got en=%0d done=%0d want 0 1", en, done); end
    checks++; if (busy !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL abort_idle: got busy=%0d ready=%0d want 0 1", busy, cmd_ready); end
    checks++; if (position !== 32'sd50) begin errors++; $display("FAIL abort_position: got %0d want 50", position); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_done_width: got %0d want 0", done); end
  endtask

  task automatic test_reset_mid();
    issue(1'b0, 1'b1, 24'd500);
    for (int i = 0; i < 10; i++) step_pulse();
    checks++; if (speed !== 16'd55000) begin errors++; $display("FAIL rmid_speed10: got %0d want 55000", speed); end
    nrst = 1'b0;
    #1;
    checks++; if (en !== 1'b0 || busy !== 1'b0 || dir !== 1'b0) begin errors++; $display("FAIL rmid_ctrl: got en=%0d busy=%0d dir=%0d want 0 0 0", en, busy, dir); end
    checks++; if (speed !== 16'd60000 || position !== 32'sd0) begin errors++; $display("FAIL rmid_data: got speed=%0d pos=%0d want 60000 0", speed, position); end
    @(negedge clk);
    nrst = 1'b1;
    done_seen = 0;
    repeat (3) begin @(negedge clk); if (done) done_seen++; end
    checks++; if (done_seen != 0) begin errors++; $display("FAIL rmid_no_done: got %0d want 0", done_seen); end
    issue(1'b0, 1'b1, 24'd3);
    for (int i = 0; i < 3; i++) step_pulse();
    checks++; if (done_seen != 1 || position !== 32'sd3) begin errors++; $display("FAIL rmid_next_cmd: got done=%0d pos=%0d want 1 3", done_seen, position); end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    nrst = 1'b0; cmd_valid = 1'b0; cmd_home = 1'b0; cmd_dir = 1'b0; cmd_steps = '0;
    abort = 1'b0; clr_fault = 1'b0; mtr_step = 1'b0; mtr_nhome = 1'b1; mtr_nflt = 1'b1;
    @(negedge clk);
    test_reset();
    test_zero_steps();
    test_move_200();
    test_move_3();
    test_homing();
    test_fault();
    test_abort();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
